// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the CPU data-memory bus, owning the data RAM.
// Decodes the address window, performs byte-lane stores, and returns registered read
// data one cycle after the read edge. Out-of-window accesses raise a one-cycle error pulse.
// Optional feature macro: DMEM_BOOT_CLEAR_EN (reset sweeps the RAM to zero while oBusy=1).
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic        iWriteEnable,
  input  logic        iReadEnable,
  input  logic [3:0]  iByteEnable,
  output logic [31:0] oReadData,
  output logic        oAddrError,
  output logic        oBusy
);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rdata_q;
  logic        err_q;

  // Window decode in 33 bits so a window ending at 2^32 does not wrap.
  logic [32:0]      addr_ext;
  logic [32:0]      base_ext;
  logic [32:0]      limit_ext;
  logic             hit;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             unused_offset;

  assign addr_ext  = {1'b0, iAddress};
  assign base_ext  = {1'b0, BASE_ADDR};
  assign limit_ext = base_ext + ({1'b0, 32'(DEPTH_WORDS)} << 2);
  assign hit       = (addr_ext >= base_ext) && (addr_ext < limit_ext);
  assign offset    = iAddress - BASE_ADDR;
  assign idx       = offset[IDX_W+1:2];
  // Byte-offset bits and bits above the window never select a word.
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

`ifdef DMEM_BOOT_CLEAR_EN
  typedef enum logic [0:0] {StReady, StClear} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // State register: reset always restarts the sweep from word 0.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep one word per cycle, return to READY after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StReady: begin
        cnt_d = '0;
      end
      StClear: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == LastIdx) begin
          state_d = StReady;
        end
      end
    endcase
  end

  assign busy    = (state_q == StClear);
  assign clr_idx = cnt_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  logic acc_ok;
  logic wr_en;

  assign acc_ok = hit & ~busy;
  assign wr_en  = iRST & iWriteEnable & acc_ok;

  // RAM write port: sweep clear has priority; stores update only enabled lanes.
  always_ff @(posedge iCLK) begin
    if (iRST && clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (iByteEnable[k]) begin
          mem[idx][8*k +: 8] <= iWriteData[8*k +: 8];
        end
      end
    end
  end

  // Registered read: old word on a same-edge store; zero when missed or busy.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      rdata_q <= '0;
    end else if (iReadEnable) begin
      rdata_q <= acc_ok ? mem[idx] : '0;
    end
  end

  // Error pulse for enabled accesses outside the window; suppressed while busy.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (iReadEnable | iWriteEnable) & ~hit & ~busy;
    end
  end

  assign oReadData  = rdata_q;
  assign oAddrError = err_q;
  assign oBusy      = busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder; honours DMEM_BOOT_CLEAR_EN when defined.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;
  logic        oAddrError;
  logic        oBusy;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iAddress     (iAddress),
    .iWriteData   (iWriteData),
    .iWriteEnable (iWriteEnable),
    .iReadEnable  (iReadEnable),
    .iByteEnable  (iByteEnable),
    .oReadData    (oReadData),
    .oAddrError   (oAddrError),
    .oBusy        (oBusy)
  );

  always #5 iCLK = ~iCLK;

  // One bus cycle: drive at negedge, let the posedge act, return at the next negedge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic re, input logic [3:0] be);
    iAddress     = a;
    iWriteData   = d;
    iWriteEnable = we;
    iReadEnable  = re;
    iByteEnable  = be;
    @(negedge iCLK);
    iWriteEnable = 1'b0;
    iReadEnable  = 1'b0;
  endtask

  // Wait (bounded) for the boot sweep to finish; returns the number of busy samples.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (oBusy && cnt < 3000) begin
      cnt++;
      @(negedge iCLK);
    end
  endtask

  task automatic test_reset();
    int c;
    iRST = 1'b0;
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata got %h want %h", oReadData, 32'h0);
    end
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got %b want 0", oAddrError);
    end
`ifdef DMEM_BOOT_CLEAR_EN
    n_cmp++;
    if (oBusy !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy got %b want 1", oBusy);
    end
    iRST = 1'b1;
    wait_ready(c);
    n_cmp++;
    if (oBusy !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready_timeout got busy %b want 0", oBusy);
    end
`else
    n_cmp++;
    if (oBusy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", oBusy);
    end
    iRST = 1'b1;
`endif
  endtask

  task automatic test_write_read();
    cyc(BASE + 32'd8, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL write_no_read got %h want %h", oReadData, 32'h0);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read_full got %h want %h", oReadData, 32'hDEADBEEF);
    end
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL hit_no_err got %b want 0", oAddrError);
    end
  endtask

  task automatic test_byte_lane();
    cyc(BASE + 32'd8, 32'h0000AB00, 1'b1, 1'b0, 4'b0010);
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hDEADABEF) begin
      n_bad++; $display("FAIL byte_lane got %h want %h", oReadData, 32'hDEADABEF);
    end
  endtask

  task automatic test_rw_same_edge();
    cyc(BASE + 32'd8, 32'h12345678, 1'b1, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hDEADABEF) begin
      n_bad++; $display("FAIL rbw_old got %h want %h", oReadData, 32'hDEADABEF);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h12345678) begin
      n_bad++; $display("FAIL rbw_new got %h want %h", oReadData, 32'h12345678);
    end
    // Idle cycle: read data holds.
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (oReadData !== 32'h12345678) begin
      n_bad++; $display("FAIL rdata_hold got %h want %h", oReadData, 32'h12345678);
    end
  endtask

  task automatic test_miss();
    cyc(32'h0000_0000, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL miss_rdata got %h want %h", oReadData, 32'h0);
    end
    n_cmp++;
    if (oAddrError !== 1'b1) begin
      n_bad++; $display("FAIL miss_err got %b want 1", oAddrError);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL miss_err_pulse got %b want 0", oAddrError);
    end
    // Low address bits are ignored: BASE+10 selects the same word as BASE+8.
    cyc(BASE + 32'd10, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h12345678) begin
      n_bad++; $display("FAIL miss_ram_kept got %h want %h", oReadData, 32'h12345678);
    end
    // Zero byte enables on a hit: no change, no error.
    cyc(BASE + 32'd8, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h0);
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL be0_err got %b want 0", oAddrError);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h12345678) begin
      n_bad++; $display("FAIL be0_noop got %h want %h", oReadData, 32'h12345678);
    end
  endtask

  task automatic test_boundaries();
    cyc(BASE, 32'hA5A5A5A5, 1'b1, 1'b0, 4'hF);
    cyc(BASE + 32'd4092, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF);
    cyc(BASE + 32'd4092, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL top_word got %h want %h", oReadData, 32'hCAFEF00D);
    end
    cyc(BASE + 32'd4096, 32'h11111111, 1'b1, 1'b0, 4'hF);
    n_cmp++;
    if (oAddrError !== 1'b1) begin
      n_bad++; $display("FAIL above_err got %b want 1", oAddrError);
    end
    cyc(BASE - 32'd4, 32'h22222222, 1'b1, 1'b0, 4'hF);
    n_cmp++;
    if (oAddrError !== 1'b1) begin
      n_bad++; $display("FAIL below_err got %b want 1", oAddrError);
    end
    cyc(BASE, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL above_nowrite got %h want %h", oReadData, 32'hA5A5A5A5);
    end
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL err_cleared got %b want 0", oAddrError);
    end
    cyc(BASE + 32'd4092, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL below_nowrite got %h want %h", oReadData, 32'hCAFEF00D);
    end
  endtask

  task automatic test_warm_reset();
    iRST = 1'b0;
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL warm_reset_rdata got %h want %h", oReadData, 32'h0);
    end
    iRST = 1'b1;
`ifndef DMEM_BOOT_CLEAR_EN
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h12345678) begin
      n_bad++; $display("FAIL warm_reset_ram_kept got %h want %h", oReadData, 32'h12345678);
    end
`endif
  endtask

`ifdef DMEM_BOOT_CLEAR_EN
  task automatic test_boot_clear();
    int c;
    // Single reset edge, then count busy cycles.
    iRST = 1'b0;
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    iRST = 1'b1;
    wait_ready(c);
    n_cmp++;
    if (c != 1024) begin
      n_bad++; $display("FAIL busy_len got %0d want %0d", c, 1024);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL cleared_word got %h want %h", oReadData, 32'h0);
    end
    cyc(BASE + 32'd8, 32'h77777777, 1'b1, 1'b0, 4'hF);
    // Restart the sweep partway through.
    iRST = 1'b0;
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    iRST = 1'b1;
    // Accesses while busy: miss gives no error, read returns zero.
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oAddrError !== 1'b0) begin
      n_bad++; $display("FAIL busy_no_err got %b want 0", oAddrError);
    end
    for (int i = 0; i < 498; i++) cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    iRST = 1'b0;
    cyc(BASE, 32'h0, 1'b0, 1'b0, 4'h0);
    iRST = 1'b1;
    wait_ready(c);
    n_cmp++;
    if (c != 1024) begin
      n_bad++; $display("FAIL busy_len_restart got %0d want %0d", c, 1024);
    end
    cyc(BASE + 32'd8, 32'h0, 1'b0, 1'b1, 4'hF);
    n_cmp++;
    if (oReadData !== 32'h0) begin
      n_bad++; $display("FAIL restart_cleared got %h want %h", oReadData, 32'h0);
    end
  endtask
`endif

  initial begin
    iRST         = 1'b0;
    iAddress     = '0;
    iWriteData   = '0;
    iWriteEnable = 1'b0;
    iReadEnable  = 1'b0;
    iByteEnable  = '0;
    @(negedge iCLK);
    test_reset();
    test_write_read();
    test_byte_lane();
    test_rw_same_edge();
    test_miss();
    test_boundaries();
    test_warm_reset();
`ifdef DMEM_BOOT_CLEAR_EN
    test_boot_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
